seq_divide: RTL and testbench
=============================

SEQ_DIVIDE -- requirements
Module: seq_divide

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result bit width (legal range 2..16).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 START  input  1  request; sampled on rising CLK edge.
REQ-005 IN1  input  WIDTH  dividend, unsigned; sampled only when START is accepted.
REQ-006 IN2  input  WIDTH  divisor, unsigned; sampled only when START is accepted.
REQ-007 BUSY  output  1  high while a division is in progress.
REQ-008 DONE  output  1  one-cycle pulse; results valid in this cycle.
REQ-009 QUO  output  WIDTH  quotient, registered, held until the next accepted START.
REQ-010 REM  output  WIDTH  remainder, registered, held until the next accepted START.
REQ-011 DZ  output  1  divide-by-zero flag, registered, held with results.
REQ-012 Z  output  1  zero flag: high when QUO == 0, registered, held with results.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIN; reset state IDLE.
REQ-014 START SHALL be accepted only in IDLE or FIN; START in CALC SHALL be ignored, with no side effect.
REQ-015 On acceptance (edge k), IN1/IN2 SHALL be latched, BUSY SHALL rise after edge k, and the state SHALL go to CALC (or FIN for the DZ/early-exit cases).
REQ-016 CALC SHALL run a restoring shift-subtract, one quotient bit per cycle, MSB first, for exactly WIDTH cycles.
REQ-017 The partial remainder SHALL be WIDTH+1 bits; trial subtract borrow SHALL decide the quotient bit and the restore.
REQ-018 Normal latency: DONE, QUO, REM, Z SHALL update at edge k+WIDTH; BUSY SHALL fall at the same edge.
REQ-019 FIN SHALL last one cycle (DONE=1), then return to IDLE unless START is accepted in FIN (back-to-back, no idle cycle).
REQ-020 IN2 == 0: DONE at edge k+1, QUO = all ones, REM = IN1, DZ = 1, Z = 0.
REQ-021 DZ SHALL be 0 for every non-zero divisor result.
REQ-022 IN1 == 0 with IN2 != 0 SHALL run the full WIDTH cycles: QUO = 0, REM = 0, Z = 1.
REQ-023 The invariant QUO*IN2 + REM == IN1 with REM < IN2 SHALL hold for every IN2 != 0.

Reset
REQ-024 RST high SHALL force IDLE and BUSY=0, DONE=0, QUO=0, REM=0, DZ=0, Z=0, regardless of CLK.
REQ-025 RST asserted during CALC SHALL abort the operation with no DONE pulse; after deassertion the block SHALL accept START on the first rising edge.

Configuration
REQ-026 Macro SEQ_DIVIDE_EARLY_EXIT_EN defined: when latched IN2 > IN1, the block SHALL skip CALC and produce DONE at edge k+1 with QUO=0, REM=IN1, Z=1, DZ=0.
REQ-027 Macro SEQ_DIVIDE_EARLY_EXIT_EN undefined: every non-zero divisor SHALL take exactly WIDTH cycles; results are identical either way.

Structure
REQ-028 Shared package seq_divide_pkg SHALL hold the FSM state enum (IDLE, CALC, FIN) and the default WIDTH constant.
REQ-029 One combinational sub-module seq_divide_step SHALL do the shift plus trial subtract: partial remainder and divisor in, next remainder and quotient bit out.
REQ-030 The top level SHALL hold the FSM, the iteration counter ($clog2(WIDTH)+1 bits) and the output registers only.

Verification
REQ-031 IN1=13, IN2=3, START 1 cycle -> DONE at k+4: QUO=4, REM=1, DZ=0, Z=0; BUSY high for 4 cycles.
REQ-032 IN1=9, IN2=0 -> DONE at k+1: QUO=15, REM=9, DZ=1, Z=0.
REQ-033 IN1=2, IN2=7 -> QUO=0, REM=2, Z=1; DONE at k+1 with SEQ_DIVIDE_EARLY_EXIT_EN, at k+4 without.
REQ-034 START held high continuously with IN1=15, IN2=1 -> DONE every 5 cycles, QUO=15, REM=0; mid-CALC START edges ignored.
REQ-035 RST pulsed at k+2 during 15/2 -> all outputs 0 immediately, no DONE; next START 6/3 -> QUO=2, REM=0.
REQ-036 Exhaustive 256-pair sweep -> every result matches REQ-023, or REQ-020 when IN2=0.

Source files
------------

// File: rtl/seq_divide_pkg.sv
// seq_divide_pkg: shared FSM state encoding and default operand width for seq_divide
package seq_divide_pkg;
    localparam int DEF_WIDTH = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIN  = ST_FIN
    } state_t;
endpackage

// File: rtl/seq_divide_if.sv
// seq_divide_if: request/result bundle of seq_divide.
//   start/in1/in2 : request and unsigned operands (driven by master)
//   busy/done     : progress and one-cycle completion pulse (driven by slave)
//   quo/rem/dz/z  : registered results and flags (driven by slave)
interface seq_divide_if
    import seq_divide_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dz;
    logic             z;
    modport master (output start, in1, in2, input busy, done, quo, rem, dz, z);
    modport slave  (input start, in1, in2, output busy, done, quo, rem, dz, z);
endinterface

// File: rtl/seq_divide_step.sv
// seq_divide_step: one restoring-division iteration (shift in a dividend bit, trial subtract).
//   rem  : current partial remainder (always < div)
//   din  : next dividend bit, MSB first
//   div  : divisor
//   nrem : partial remainder after the optional restore
//   qbit : quotient bit (1 when the trial subtract does not borrow)
module seq_divide_step
    import seq_divide_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] nrem,
    output logic             qbit
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    // shifted is the WIDTH+1 bit partial remainder; when no borrow occurs the
    // difference is below div, so its low WIDTH bits hold it exactly
    assign shifted = {rem, din};
    assign borrow  = shifted < {1'b0, div};
    assign diff    = shifted[WIDTH-1:0] - div;
    assign qbit    = ~borrow;
    assign nrem    = borrow ? shifted[WIDTH-1:0] : diff;
endmodule

// File: rtl/seq_divide.sv
// seq_divide: sequential unsigned restoring divider, one quotient bit per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_divide_if slave (start/in1/in2 in; busy/done/quo/rem/dz/z out)
// Optional macro SEQ_DIVIDE_EARLY_EXIT_EN: a divisor larger than the dividend
// finishes one cycle after acceptance instead of running all WIDTH iterations.
module seq_divide
    import seq_divide_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic       clk,
    input logic       rst,
    seq_divide_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t           st;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] nrem;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt;
    logic             fast;
    logic             fast_in;
    logic             qbit;
    logic             accept;
    seq_divide_step #(.WIDTH(WIDTH)) u_step (
        .rem  (prem),
        .din  (acc[WIDTH-1]),
        .div  (div),
        .nrem (nrem),
        .qbit (qbit)
    );
    // acc shifts dividend bits out at the top while quotient bits enter at the bottom
    assign q_next   = {acc[WIDTH-2:0], qbit};
    assign accept   = bus.start && st != CALC;
    assign bus.busy = st == CALC;
    assign bus.done = st == FIN;
`ifdef SEQ_DIVIDE_EARLY_EXIT_EN
    assign fast_in = bus.in2 == '0 || bus.in2 > bus.in1;
`else
    assign fast_in = bus.in2 == '0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            div     <= '0;
            acc     <= '0;
            prem    <= '0;
            cnt     <= '0;
            fast    <= 1'b0;
            bus.quo <= '0;
            bus.rem <= '0;
            bus.dz  <= 1'b0;
            bus.z   <= 1'b0;
        end else if (accept) begin
            st   <= CALC;
            div  <= bus.in2;
            acc  <= bus.in1;
            prem <= '0;
            cnt  <= '0;
            fast <= fast_in;
        end else if (st == CALC) begin
            // fast path: divide-by-zero (or divisor above dividend) resolves in one cycle
            if (fast) begin
                st      <= FIN;
                bus.quo <= div == '0 ? '1 : '0;
                bus.rem <= acc;
                bus.dz  <= div == '0;
                bus.z   <= div != '0;
            end else begin
                prem <= nrem;
                acc  <= q_next;
                cnt  <= cnt + CW'(1);
                if (cnt == LAST) begin
                    st      <= FIN;
                    bus.quo <= q_next;
                    bus.rem <= nrem;
                    bus.dz  <= 1'b0;
                    bus.z   <= q_next == '0;
                end
            end
        end else if (st == FIN) begin
            st <= IDLE;
        end
    end
endmodule

// File: tb/tb_seq_divide.sv
// tb_seq_divide: scoreboard bench for seq_divide (WIDTH=4)
module tb_seq_divide;
    localparam int W = 4;
`ifdef SEQ_DIVIDE_EARLY_EXIT_EN
    localparam int EL = 1;
`else
    localparam int EL = W;
`endif
    typedef struct {
        string      nm;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        logic       z;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    seq_divide_if #(.WIDTH(W)) bus ();
    seq_divide #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every DONE pulse must match the oldest expected result and its cycle
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done got quo=%0d rem=%0d dz=%0d z=%0d cyc=%0d", bus.quo, bus.rem, bus.dz, bus.z, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.quo !== e.q || bus.rem !== e.r || bus.dz !== e.dz || bus.z !== e.z || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL %s got quo=%0d rem=%0d dz=%0d z=%0d cyc=%0d want quo=%0d rem=%0d dz=%0d z=%0d cyc=%0d",
                             e.nm, bus.quo, bus.rem, bus.dz, bus.z, cyc, e.q, e.r, e.dz, e.z, e.cyc);
                end
            end
        end
    end

    task automatic push(input string nm, input logic [3:0] q, r, input logic dz, z, input int c);
        exp_t e;
        e.nm = nm; e.q = q; e.r = r; e.dz = dz; e.z = z; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string nm);
        tests++;
        if (bus.quo !== 4'd0 || bus.rem !== 4'd0 || bus.dz !== 1'b0 || bus.z !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL %s got quo=%0d rem=%0d dz=%0d z=%0d busy=%0d done=%0d want all 0",
                     nm, bus.quo, bus.rem, bus.dz, bus.z, bus.busy, bus.done);
        end
    endtask

    // issue one single-cycle START, then check BUSY length and that DONE arrives
    task automatic op(input string nm, input logic [3:0] a, b, q, r, input logic dz, z, input int lat);
        int nb = 0;
        bit seen = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.in1 = a; bus.in2 = b;
        push(nm, q, r, dz, z, cyc + 1 + lat);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            if (bus.busy) nb++;
            if (bus.done) seen = 1;
        end
        tests++;
        if (!seen || nb != lat) begin
            fails++;
            $display("FAIL %s_busy got busy_cycles=%0d done_seen=%0d want busy_cycles=%0d done_seen=1", nm, nb, seen, lat);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        int c;
        bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0;
        #3;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        op("d13_3",  4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 1'b0, W);
        op("dz9_0",  4'd9,  4'd0, 4'd15, 4'd9, 1'b1, 1'b0, 1);
        op("d2_7",   4'd2,  4'd7, 4'd0,  4'd2, 1'b0, 1'b1, EL);
        op("d0_5",   4'd0,  4'd5, 4'd0,  4'd0, 1'b0, 1'b1, EL);
        op("d15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 1'b0, W);
        op("d15_4",  4'd15, 4'd4, 4'd3,  4'd3, 1'b0, 1'b0, W);
        op("dz0_0",  4'd0,  4'd0, 4'd15, 4'd0, 1'b1, 1'b0, 1);
        op("d15_1",  4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0, W);
        op("d7_2",   4'd7,  4'd2, 4'd3,  4'd1, 1'b0, 1'b0, W);

        // START held high: one result every W+1 cycles, mid-CALC START ignored
        @(negedge clk);
        c = cyc;
        bus.start = 1'b1; bus.in1 = 4'd15; bus.in2 = 4'd1;
        for (int j = 0; j < 3; j++) push("b2b", 4'd15, 4'd0, 1'b0, 1'b0, c + 1 + W + (W + 1) * j);
        repeat (3 * (W + 1)) @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);

        // reset two edges into 15/2: outputs clear at once and no DONE follows
        @(negedge clk);
        bus.start = 1'b1; bus.in1 = 4'd15; bus.in2 = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("rst_abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        op("post_rst", 4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0, W);

        // every operand pair against the division identity
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] q, r;
                int lat;
                q = b == 0 ? 4'd15 : 4'(a / b);
                r = b == 0 ? 4'(a) : 4'(a % b);
                lat = b == 0 ? 1 : (b > a ? EL : W);
                op("sweep", 4'(a), 4'(b), q, r, b == 0, b != 0 && q == 0, lat);
            end
        end

        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got pending=%0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
